// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the round-robin write arbiter over a single D register.
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 8;
    localparam int BURST_DEF = 4;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first req bit searching upward from ptr+1, wrapping at N-1.
// Zero latency; no flow control, oh is all zero and vld low when nothing requests.
module rr_pick
#(
    parameter int N  = 4,
    parameter int PW = 2
)(
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic          vld
);

    always_comb begin
        oh  = '0;
        vld = |req;
        // Walk the search order backwards so the earliest hit is the last one written.
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                oh = '0;
                oh[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting N requesters bursts of writes into one shared W-bit register.
// Grant one edge after req, first write the edge after; a dropped req or a burst limit with others waiting releases the grant.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int BURST = BURST_DEF
)(
    input  logic           clk,
    input  logic           R,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] D,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   q
);

    localparam int PW = idx_w(N);
    localparam int CW = idx_w(BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST);
    localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

    state_t        state, state_nxt;
    logic [N-1:0]  gnt_nxt, ack_nxt;
    logic [W-1:0]  d_nxt, d_sel;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [PW-1:0] ptr, ptr_nxt, pick_idx;
    logic [N-1:0]  pick_oh;
    logic          pick_vld;
    logic          own_req, others;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .oh  (pick_oh),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    // ptr always names the current owner while in OWN.
    assign d_sel   = D[int'(ptr)*W +: W];
    assign own_req = |(req & gnt);
    assign others  = |(req & ~gnt);
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        d_nxt     = Q;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_nxt   = pick_oh;
                    ptr_nxt   = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (own_req) begin
                    d_nxt   = d_sel;
                    ack_nxt = gnt;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        if (others) begin
                            gnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = '0;
                        end
                    end
                end else begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            Q     <= '0;
            gnt   <= '0;
            ack   <= '0;
            state <= IDLE;
            cnt   <= '0;
            ptr   <= PTR_RST;
        end else begin
            Q     <= d_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign q = ~Q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_dff_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    typedef struct {
        int         idx;
        logic [7:0] dat;
    } wr_t;

    typedef struct {
        int idx;
        int acks;
    } rec_t;

    logic           clk;
    logic           R;
    logic [N-1:0]   req;
    logic [N*W-1:0] D;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   Q;
    logic [W-1:0]   q;

    int n_checks = 0;
    int n_fail   = 0;

    dff_write_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk (clk),
        .R   (R),
        .req (req),
        .D   (D),
        .gnt (gnt),
        .ack (ack),
        .Q   (Q),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: owner index (-1 when nobody holds the register), last winner, writes this burst.
    int         m_owner = -1;
    int         m_last  = N - 1;
    int         m_cnt   = 0;
    logic [7:0] m_q     = '0;
    wr_t        exp_q[$];

    function automatic logic [N-1:0] model_gnt(input int owner);
        logic [N-1:0] v;
        v = '0;
        if (owner >= 0) v[owner] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge R) begin
        wr_t w;
        logic [N-1:0] mine;
        if (R) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
            m_q     = '0;
            exp_q.delete();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_last  = m_owner;
                    m_cnt   = 0;
                end
            end
        end else if (req[m_owner]) begin
            m_q   = D[m_owner*W +: W];
            w.idx = m_owner;
            w.dat = m_q;
            exp_q.push_back(w);
            m_cnt++;
            mine = model_gnt(m_owner);
            if (m_cnt == BURST) begin
                if ((req & ~mine) != 0) m_owner = -1;
                else                    m_cnt   = 0;
            end
        end else begin
            m_owner = -1;
        end
    end

    // Monitor: compares every cycle and logs grant history for the directed scenarios.
    logic [N-1:0] prev_gnt = '0;
    int           cur_acks = 0;
    int           run      = 0;
    int           max_run  = 0;
    int           grant_log[$];
    rec_t         recs[$];

    always @(negedge clk) begin
        wr_t        w;
        rec_t       r;
        logic [7:0] nq;
        nq = ~m_q;
        chk("gnt", gnt, model_gnt(m_owner));
        chk("Q", Q, m_q);
        chk("q_inv", q, nq);
        if (ack != 0) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", ack, 0);
            end else begin
                w = exp_q.pop_front();
                chk("ack_idx", ack, 32'(1) << w.idx);
                chk("ack_Q", Q, w.dat);
            end
            cur_acks++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("ack_missing", ack, 32'(1) << w.idx);
            end
        end
        if (prev_gnt != 0 && gnt != prev_gnt) begin
            chk("idle_gap", gnt, 0);
            r.idx  = oh2idx(prev_gnt);
            r.acks = cur_acks;
            recs.push_back(r);
            cur_acks = 0;
        end
        if (prev_gnt == 0 && gnt != 0) grant_log.push_back(oh2idx(gnt));
        prev_gnt = gnt;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        recs.delete();
        cur_acks = 0;
        run      = 0;
        max_run  = 0;
    endtask

    task automatic reset_dut();
        R = 1'b1;
        cyc(1);
        R = 1'b0;
        cyc(1);
    endtask

    initial begin
        R   = 1'b1;
        req = '0;
        D   = '0;
        #1;
        chk("rst_Q", Q, 8'h00);
        chk("rst_q", q, 8'hFF);
        chk("rst_gnt", gnt, 0);
        #9 R = 1'b0;
        cyc(1);

        // Single requester 1 for one grant cycle plus three writes.
        clear_logs();
        D = {$urandom};
        D[15:8] = 8'hA5;
        req = 4'b0010;
        cyc(1);
        chk("s1_gnt", gnt, 4'b0010);
        cyc(3);
        req = '0;
        cyc(3);
        chk("s1_Q", Q, 8'hA5);
        chk("s1_nrec", recs.size(), 1);
        if (recs.size() > 0) begin
            chk("s1_idx", recs[0].idx, 1);
            chk("s1_acks", recs[0].acks, 3);
        end
        chk("s1_idle", gnt, 0);

        // All four request after reset: rotation 0,1,2,3,0.
        reset_dut();
        clear_logs();
        D   = {$urandom};
        req = 4'b1111;
        cyc(24);
        req = '0;
        cyc(6);
        chk("s2_ngrants", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("s2_order", grant_log[i], i % N);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < recs.size()) chk("s2_burst", recs[i].acks, BURST);
        end

        // Two contenders: each gets exactly BURST writes per grant.
        reset_dut();
        clear_logs();
        D   = {$urandom};
        req = 4'b0011;
        cyc(12);
        req = '0;
        cyc(6);
        chk("s3_nrec", recs.size() >= 2, 1);
        if (recs.size() >= 2) begin
            chk("s3_r0_idx", recs[0].idx, 0);
            chk("s3_r0_acks", recs[0].acks, BURST);
            chk("s3_r1_idx", recs[1].idx, 1);
            chk("s3_r1_acks", recs[1].acks, BURST);
        end

        // Lone requester 2 keeps its grant across burst boundaries.
        reset_dut();
        clear_logs();
        D   = {$urandom};
        req = 4'b0100;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            chk("s4_gnt", gnt, 4'b0100);
            cyc(1);
        end
        req = '0;
        cyc(3);
        chk("s4_nrec", recs.size(), 1);
        if (recs.size() > 0) chk("s4_acks", recs[0].acks, 10);
        chk("s4_run", max_run, 10);
        chk("s4_ngrants", grant_log.size(), 1);

        // Reset in the middle of a burst, then requester 0 must win first.
        reset_dut();
        clear_logs();
        D = {$urandom};
        D[15:8] = 8'h3C;
        req = 4'b0010;
        cyc(2);
        chk("s5_pre_Q", Q, 8'h3C);
        R = 1'b1;
        #1;
        chk("s5_Q", Q, 0);
        chk("s5_gnt", gnt, 0);
        chk("s5_ack", ack, 0);
        req = 4'b0011;
        cyc(1);
        clear_logs();
        R = 1'b0;
        cyc(3);
        chk("s5_nfirst", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("s5_first", grant_log[0], 0);
        req = '0;
        cyc(8);

        // Random traffic with occasional reset pulses.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            D = {$urandom};
            R = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        R   = 1'b0;
        req = '0;
        cyc(10);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, meaning the width of the shared D register.
REQ-003 The block SHALL have parameter BURST, default 4, meaning the maximum writes per grant when another requester is pending.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-005 The block SHALL have port R  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req  input  N  per-requester write request, level-sensitive.
REQ-007 The block SHALL have port D  input  N*W  write data, with requester i's data in bits [i*W +: W].
REQ-008 The block SHALL have port gnt  output  N  registered one-hot grant, or all zero.
REQ-009 The block SHALL have port ack  output  N  one-cycle pulse that marks a completed write by requester i.
REQ-010 The block SHALL have port Q  output  W  shared register contents.
REQ-011 The block SHALL have port q  output  W  bitwise complement of Q at all times.

Function
REQ-012 The FSM SHALL have states IDLE and OWN, and gnt SHALL be all zero in IDLE.
REQ-013 In IDLE, with any req bit high at a clock edge, the block SHALL pick the first requester with req high, searching upward from ptr+1 modulo N, then set gnt to that one-hot value, set ptr to the chosen index, clear cnt, and enter OWN.
REQ-014 In IDLE with req all zero, the block SHALL remain in IDLE with no state change.
REQ-015 In OWN, at each edge where req[g] is high, the block SHALL load Q from requester g's D slice, pulse ack[g] high for the following cycle, and increment cnt.
REQ-016 In OWN, at an edge where req[g] is low, the block SHALL perform no write, clear gnt, and enter IDLE.
REQ-017 If a write makes cnt equal BURST and any other req bit is high at that edge, the block SHALL clear gnt and enter IDLE.
REQ-018 If a write makes cnt equal BURST and no other req bit is high, the block SHALL keep the grant, set cnt to 0, and stay in OWN.
REQ-019 Latency: req rising before edge k SHALL give gnt high after edge k, the first write at edge k+1, and the ack pulse after edge k+1.
REQ-020 After every release, IDLE SHALL last at least one full cycle, so there is no back-to-back grant to two requesters.
REQ-021 Requester bits other than g SHALL NOT affect Q, and their D slices SHALL be ignored.
REQ-022 cnt SHALL be wide enough for BURST and SHALL NOT wrap before the comparison at REQ-017.
REQ-023 The ptr search SHALL wrap from N-1 to 0.
REQ-024 Simultaneous requests SHALL be resolved only by the REQ-013 rotation, with no fixed priority.
REQ-025 Q SHALL hold its value in all cycles without a write.

Reset
REQ-026 While R is high, the block SHALL immediately hold Q=0, q=all ones, gnt=0, ack=0, state=IDLE, cnt=0, and ptr=N-1, with no clock edge required.
REQ-027 When R is asserted mid-burst, the block SHALL abort the grant with no write at that edge.
REQ-028 The first arbitration after R deasserts SHALL favour requester 0.

Structure
REQ-029 The state encoding and the parameter defaults (N, W, BURST) SHALL be placed in shared package dff_arb_pkg.
REQ-030 Round-robin selection SHALL be one combinational sub-module, rr_pick, with inputs req and ptr and outputs a one-hot value and a valid flag.
REQ-031 All state (Q, gnt, ack, state, cnt, ptr) SHALL be updated in a single clocked process with asynchronous reset on R.

Verification
REQ-032 Reset check: with R=1 at t=0, the bench SHALL confirm Q=8'h00, q=8'hFF and gnt=0 before the first edge, while R is released after 10 ns.
REQ-033 Single requester: with req=4'b0010 held for 3 cycles and D slice1 = 8'hA5, the bench SHALL confirm gnt=4'b0010 one cycle later, Q=8'hA5, exactly 3 ack[1] pulses, then IDLE after req drops.
REQ-034 Simultaneous requests after reset: with req=4'b1111, the bench SHALL confirm grant order 0,1,2,3,0, with each grant separated by one IDLE cycle.
REQ-035 Burst limit: with req=4'b0011 both held and BURST=4, the bench SHALL confirm requester 0 gets exactly 4 acks, then requester 1 gets 4 acks.
REQ-036 Burst renewal: with req=4'b0100 held alone for 10 cycles, the bench SHALL confirm gnt stays 4'b0100, there are 10 contiguous acks, and there is no IDLE gap.
REQ-037 Mid-burst reset: with R pulsed high during the second write of a burst, the bench SHALL confirm Q=0 and gnt=0 immediately, no ack, and that requester 0 is granted first after release.
